// File: rtl/note_event_if.sv
// Event output stream of the note event tracker: FIFO head fields with a valid/ready handshake.
interface note_event_if #(
  parameter int NUM_CH   = 5,
  parameter int NOTE_W   = 8,
  parameter int RHYTHM_W = 4,
  parameter int CELL_W   = 6
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                event_valid_out;
  logic                event_ready_in;
  logic [CELL_W-1:0]   event_cell_out;
  logic [CH_W-1:0]     event_channel_out;
  logic [NOTE_W-1:0]   event_note_out;
  logic [RHYTHM_W-1:0] event_rhythm_out;

  modport master (
    output event_valid_out, event_cell_out, event_channel_out, event_note_out, event_rhythm_out,
    input  event_ready_in
  );

  modport slave (
    input  event_valid_out, event_cell_out, event_channel_out, event_note_out, event_rhythm_out,
    output event_ready_in
  );
endinterface

// File: rtl/note_event_tracker.sv
// Debounces NUM_CH note channels, turns each committed change into an event record and
// queues it through per-channel pending slots into a first-word-fall-through FIFO.
module note_event_tracker #(
  parameter int NUM_CH       = 5,
  parameter int NOTE_W       = 8,
  parameter int RHYTHM_W     = 4,
  parameter int CELL_W       = 6,
  parameter int STABLE_COUNT = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                                  clk_in,
  input  logic                                  rst_n_in,
  input  logic                                  sample_valid_in,
  input  logic [NUM_CH-1:0][NOTE_W-1:0]         notes_in,
  input  logic [NUM_CH-1:0][RHYTHM_W-1:0]       rhythms_in,
  input  logic [CELL_W-1:0]                     cell_in,
  output logic [NUM_CH-1:0][RHYTHM_W+NOTE_W-1:0] detected_note_out,
  output logic                                  cell_change_out,
  note_event_if.master                          evt,
  output logic                                  overflow_out,
  input  logic                                  clear_overflow_in
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(STABLE_COUNT + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int EV_W  = CELL_W + CH_W + NOTE_W + RHYTHM_W;
  localparam logic [NOTE_W-1:0] REST    = {NOTE_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PW-1:0]     PTR_ONE = PW'(1);

  logic [CELL_W-1:0]               cell_r;
  logic [NUM_CH-1:0][NOTE_W-1:0]   cand_r;
  logic [NUM_CH-1:0][NOTE_W-1:0]   comm_r;
  logic [NUM_CH-1:0][CNT_W-1:0]    cnt_r;
  logic [NUM_CH-1:0]               pend_r;
  logic [CELL_W-1:0]               pcell_r [NUM_CH];
  logic [NOTE_W-1:0]               pnote_r [NUM_CH];
  logic [RHYTHM_W-1:0]             prhy_r  [NUM_CH];
  logic [EV_W-1:0]                 mem_r   [FIFO_DEPTH];
  logic [PW-1:0]                   wr_ptr_r;
  logic [PW-1:0]                   rd_ptr_r;

  logic                            cell_chg_s;
  logic [NUM_CH-1:0][NOTE_W-1:0]   cand_nx_s;
  logic [NUM_CH-1:0][CNT_W-1:0]    cnt_nx_s;
  logic [NUM_CH-1:0]               commit_s;
  logic [NUM_CH-1:0]               pend_nx_s;
  logic [NUM_CH-1:0]               drained_s;
  logic                            drain_any_s;
  logic [CH_W-1:0]                 drain_idx_s;
  logic                            empty_s;
  logic                            full_s;
  logic                            pop_s;
  logic                            push_s;
  logic                            ovf_set_s;
  logic [EV_W-1:0]                 wr_data_s;
  logic [EV_W-1:0]                 head_s;

  // Debounce: candidate/count update and commit decision for the current sample.
  always_comb begin
    cell_chg_s = sample_valid_in && (cell_in != cell_r);
    for (int i = 0; i < NUM_CH; i++) begin
      cand_nx_s[i] = cand_r[i];
      cnt_nx_s[i]  = cnt_r[i];
      commit_s[i]  = 1'b0;
      if (sample_valid_in) begin
        // A cell change restarts every channel with this sample as its first one.
        if (cell_chg_s || (notes_in[i] != cand_r[i])) begin
          cand_nx_s[i] = notes_in[i];
          cnt_nx_s[i]  = CNT_ONE;
        end else if (cnt_r[i] < CNT_MAX) begin
          cnt_nx_s[i] = cnt_r[i] + CNT_ONE;
        end else begin
          cnt_nx_s[i] = CNT_MAX;
        end
        commit_s[i] = (cnt_nx_s[i] == CNT_MAX) &&
                      (cand_nx_s[i] != (cell_chg_s ? REST : comm_r[i]));
      end else begin
        commit_s[i] = 1'b0;
      end
    end
  end

  // Pending-slot arbitration, FIFO status and overflow detection.
  always_comb begin
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s       = !empty_s && evt.event_ready_in;
    drain_any_s = 1'b0;
    drain_idx_s = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend_r[i]) begin
        drain_any_s = 1'b1;
        drain_idx_s = CH_W'(i);
      end else begin
        drain_idx_s = drain_idx_s;
      end
    end
    push_s    = drain_any_s && (!full_s || pop_s);
    wr_data_s = {pcell_r[drain_idx_s], drain_idx_s, pnote_r[drain_idx_s], prhy_r[drain_idx_s]};
    ovf_set_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      drained_s[i] = push_s && (drain_idx_s == CH_W'(i));
      pend_nx_s[i] = (pend_r[i] && !drained_s[i] && !cell_chg_s) || commit_s[i];
      ovf_set_s    = ovf_set_s || (commit_s[i] && pend_r[i] && !drained_s[i] && !cell_chg_s);
    end
  end

  // FIFO head presented on the event interface; fields read as zero while empty.
  always_comb begin
    head_s              = mem_r[rd_ptr_r[AW-1:0]];
    evt.event_valid_out = !empty_s;
    if (!empty_s) begin
      {evt.event_cell_out, evt.event_channel_out, evt.event_note_out, evt.event_rhythm_out} = head_s;
    end else begin
      {evt.event_cell_out, evt.event_channel_out, evt.event_note_out, evt.event_rhythm_out} = '0;
    end
  end

  // Channel state, committed notes and pending slots.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cell_r          <= '0;
      cell_change_out <= 1'b0;
      pend_r          <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cand_r[i]            <= REST;
        comm_r[i]            <= REST;
        cnt_r[i]             <= '0;
        detected_note_out[i] <= {{RHYTHM_W{1'b0}}, REST};
        pcell_r[i]           <= '0;
        pnote_r[i]           <= '0;
        prhy_r[i]            <= '0;
      end
    end else begin
      cell_change_out <= cell_chg_s;
      cell_r          <= cell_chg_s ? cell_in : cell_r;
      pend_r          <= pend_nx_s;
      for (int i = 0; i < NUM_CH; i++) begin
        cand_r[i] <= cand_nx_s[i];
        cnt_r[i]  <= cnt_nx_s[i];
        if (commit_s[i]) begin
          comm_r[i]            <= cand_nx_s[i];
          detected_note_out[i] <= {rhythms_in[i], cand_nx_s[i]};
          pcell_r[i]           <= cell_in;
          pnote_r[i]           <= cand_nx_s[i];
          prhy_r[i]            <= rhythms_in[i];
        end else if (cell_chg_s) begin
          comm_r[i]            <= REST;
          detected_note_out[i] <= {{RHYTHM_W{1'b0}}, REST};
        end else begin
          comm_r[i] <= comm_r[i];
        end
      end
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      overflow_out <= 1'b0;
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      if (ovf_set_s) begin
        overflow_out <= 1'b1;
      end else if (clear_overflow_in) begin
        overflow_out <= 1'b0;
      end else begin
        overflow_out <= overflow_out;
      end
    end
  end

  // FIFO storage, no reset needed since reads are masked while empty.
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data_s;
    end
  end
endmodule
